// File: rtl/jk_pkg.sv
`default_nettype none
// ============================================================================
// jk_pkg : mode encodings shared by the JK register/counter
// Rev 1.0
// ============================================================================
package jk_pkg;

  localparam logic [1:0] MODE_JK = 2'b00;
  localparam logic [1:0] MODE_UP = 2'b01;
  localparam logic [1:0] MODE_DN = 2'b10;
  localparam logic [1:0] MODE_LD = 2'b11;

endpackage : jk_pkg
`default_nettype wire

// File: rtl/jk_cell.sv
`default_nettype none
// ============================================================================
// jk_cell : combinational next-state of a single JK bit
// Rev 1.0
// ============================================================================
module jk_cell (
  input  logic i_j,
  input  logic i_k,
  input  logic i_q,
  output logic o_q_next
);

  always_comb begin
    o_q_next = i_q;
    case ({i_j, i_k})
      2'b00:   o_q_next = i_q;
      2'b01:   o_q_next = 1'b0;
      2'b10:   o_q_next = 1'b1;
      default: o_q_next = ~i_q;
    endcase
  end

endmodule : jk_cell
`default_nettype wire

// File: rtl/jk_reg_counter.sv
`default_nettype none
// ============================================================================
// jk_reg_counter : WIDTH-bit JK register with up/down count, load and preset
// Rev 1.0
// ============================================================================
module jk_reg_counter
  import jk_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter bit               WRAP    = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  input  logic             pr_en,
  input  logic [WIDTH-1:0] pr,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nq,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  logic [WIDTH-1:0] w_up_t;
  logic [WIDTH-1:0] w_dn_t;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_q_next;
  logic             w_term;
  logic             w_hold_sat;

  // Toggle chain: a bit flips when every lower bit is 1 (up) or 0 (down)
  assign w_up_t[0] = 1'b1;
  assign w_dn_t[0] = 1'b1;
  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_chain
      assign w_up_t[gi] = w_up_t[gi-1] &  r_q[gi-1];
      assign w_dn_t[gi] = w_dn_t[gi-1] & ~r_q[gi-1];
    end
  endgenerate

  // Load is expressed as J=d, K=~d so every mode goes through the cells
  always_comb begin
    w_j = j;
    w_k = k;
    case (mode)
      MODE_UP: begin w_j = w_up_t; w_k = w_up_t; end
      MODE_DN: begin w_j = w_dn_t; w_k = w_dn_t; end
      MODE_LD: begin w_j = d;      w_k = ~d;     end
      default: begin w_j = j;      w_k = k;      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_cell u_cell (
        .i_j      (w_j[gi]),
        .i_k      (w_k[gi]),
        .i_q      (r_q[gi]),
        .o_q_next (w_q_next[gi])
      );
    end
  endgenerate

  assign w_term     = ((mode == MODE_UP) && (&r_q)) || ((mode == MODE_DN) && (r_q == '0));
  assign w_hold_sat = w_term && (WRAP == 1'b0);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_q   <= RST_VAL;
      r_ovf <= 1'b0;
    end else begin
      if (pr_en) begin
        r_q <= r_q | pr;
      end else if (en && !w_hold_sat) begin
        r_q <= w_q_next;
      end
      // A wrap/saturate event outranks a simultaneous clear request
      if (!pr_en && en && w_term) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign q   = r_q;
  assign nq  = ~r_q;
  assign tc  = en & w_term;
  assign ovf = r_ovf;

endmodule : jk_reg_counter
`default_nettype wire

// File: tb/tb_jk_reg_counter.sv
`default_nettype none
// ============================================================================
// tb_jk_reg_counter : directed self-checking bench, WRAP=1 and WRAP=0 instances
// Rev 1.0
// ============================================================================
module tb_jk_reg_counter;

  logic       clk;
  logic       clr;
  logic       en;
  logic [1:0] mode;
  logic [7:0] j;
  logic [7:0] k;
  logic [7:0] d;
  logic       pr_en;
  logic [7:0] pr;
  logic       ovf_clr;
  logic [7:0] q_w, nq_w, q_s, nq_s;
  logic       tc_w, ovf_w, tc_s, ovf_s;

  int n_assert = 0;
  int n_fail   = 0;

  jk_reg_counter #(.WIDTH(8), .RST_VAL(8'h5A), .WRAP(1'b1)) u_dut_wrap (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .j(j), .k(k), .d(d),
    .pr_en(pr_en), .pr(pr), .ovf_clr(ovf_clr),
    .q(q_w), .nq(nq_w), .tc(tc_w), .ovf(ovf_w)
  );

  jk_reg_counter #(.WIDTH(8), .RST_VAL(8'h5A), .WRAP(1'b0)) u_dut_sat (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .j(j), .k(k), .d(d),
    .pr_en(pr_en), .pr(pr), .ovf_clr(ovf_clr),
    .q(q_s), .nq(nq_s), .tc(tc_s), .ovf(ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b0; en = 1'b0; mode = 2'b00; j = '0; k = '0; d = '0;
    pr_en = 1'b0; pr = '0; ovf_clr = 1'b0;
    @(negedge clk);

    // Reset
    clr = 1'b1; tick();
    check("rst_q",    q_w,  8'h5A);
    check("rst_nq",   nq_w, 8'hA5);
    check("rst_ovf",  {7'b0, ovf_w}, 8'h00);
    check("rst_q_s",  q_s,  8'h5A);
    clr = 1'b0;

    // JK per-bit operation
    en = 1'b1; mode = 2'b11; d = 8'hF0; tick();
    check("load_f0", q_w, 8'hF0);
    mode = 2'b00; j = 8'h0F; k = 8'hC3; tick();
    check("jk_mix",    q_w,  8'h3F);
    check("jk_mix_nq", nq_w, 8'hC0);
    check("jk_mode_tc", {7'b0, tc_w}, 8'h00);
    j = 8'hFF; k = 8'hFF; tick();
    check("jk_toggle", q_w, 8'hC0);
    j = 8'h00; k = 8'h00; tick();
    check("jk_hold", q_w, 8'hC0);

    // Count up through terminal count
    mode = 2'b11; d = 8'hFE; tick();
    mode = 2'b01; #1;
    check("up_tc_fe", {7'b0, tc_w}, 8'h00);
    tick();
    check("up_q_ff",  q_w, 8'hFF);
    check("up_tc_ff", {7'b0, tc_w}, 8'h01);
    check("up_ovf_pre", {7'b0, ovf_w}, 8'h00);
    tick();
    check("up_wrap_q",   q_w, 8'h00);
    check("up_wrap_ovf", {7'b0, ovf_w}, 8'h01);
    check("up_sat_q",    q_s, 8'hFF);
    check("up_sat_ovf",  {7'b0, ovf_s}, 8'h01);

    // Count down through zero
    mode = 2'b11; d = 8'h01; ovf_clr = 1'b1; tick();
    ovf_clr = 1'b0;
    check("ld01_ovf_clr", {7'b0, ovf_w}, 8'h00);
    mode = 2'b10; tick();
    check("dn_q_00",  q_w, 8'h00);
    check("dn_tc_00", {7'b0, tc_w}, 8'h01);
    tick();
    check("dn_wrap_q",   q_w, 8'hFF);
    check("dn_wrap_ovf", {7'b0, ovf_w}, 8'h01);
    check("dn_sat_q",    q_s, 8'h00);
    check("dn_sat_ovf",  {7'b0, ovf_s}, 8'h01);
    en = 1'b0; #1;
    check("tc_gated_en", {7'b0, tc_w}, 8'h00);
    ovf_clr = 1'b1; tick();
    ovf_clr = 1'b0;
    check("ovf_clr", {7'b0, ovf_w}, 8'h00);
    check("en0_hold", q_w, 8'hFF);

    // Priority: preset over load, clr over preset, en=0 holds
    en = 1'b1; mode = 2'b11; d = 8'h01; tick();
    d = 8'h33; pr_en = 1'b1; pr = 8'h80; tick();
    check("pr_wins", q_w, 8'h81);
    clr = 1'b1; tick();
    check("clr_wins", q_w, 8'h5A);
    clr = 1'b0; pr_en = 1'b0; en = 1'b0; d = 8'hAA; tick();
    check("en0_ld_hold", q_w, 8'h5A);
    pr_en = 1'b1; pr = 8'h01; tick();
    check("pr_en0", q_w, 8'h5B);
    pr_en = 1'b0;

    // Wrap with ovf_clr in the same cycle: set wins
    en = 1'b1; mode = 2'b11; d = 8'hFF; tick();
    mode = 2'b01; ovf_clr = 1'b1; tick();
    check("set_wins_q",   q_w, 8'h00);
    check("set_wins_ovf", {7'b0, ovf_w}, 8'h01);
    en = 1'b0; tick();
    check("ovf_clr_next", {7'b0, ovf_w}, 8'h00);
    ovf_clr = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_jk_reg_counter
`default_nettype wire
